id_pipe: RTL and testbench
==========================

Name: id_pipe

Overview:
Registered RISC-V instruction-decode stage. It is the parametrised successor to the single-cycle field splitter.
- Accepts a fetched instruction and its PC over a valid/ready handshake.
- Produces fully sign-extended XLEN immediates for every base format (I/S/B/U/J), source-use flags and an illegal-instruction flag.
- Holds the result in one output register slot with backpressure and flush.
- Sits between fetch and execute in the pipelined core.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64. Immediates are sign-extended to XLEN. At 64, OP-IMM-32/OP-32 are legal and shamt is 6 bits.
PC_W, 32, width of the PC carried alongside the instruction.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept this cycle
in_instr  in  32  raw instruction
in_pc  in  PC_W  instruction address
flush  in  1  kill the held result and drop any same-cycle input
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute consumes the bundle
out_pc  out  PC_W  registered PC
out_opcode  out  7  instr[6:0]
out_rd  out  5  instr[11:7]
out_rs1  out  5  instr[19:15]
out_rs2  out  5  instr[24:20]
out_funct3  out  3  instr[14:12]
out_funct7  out  7  instr[31:25]
out_imm  out  XLEN  sign-extended immediate
out_imm_sel  out  3  0=none, 1=I, 2=S, 3=B, 4=U, 5=J
out_use_rs1  out  1  rs1 is read
out_use_rs2  out  1  rs2 is read
out_illegal  out  1  unsupported or malformed encoding

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0 and every payload output is 0.
  - Deassertion is synchronised externally; the first rising edge after release is a normal cycle.
- in_ready = !out_valid || out_ready (combinational). The bundle register loads when in_valid && in_ready && !flush.
- Latency: 1 cycle. A bundle accepted at edge N is visible with out_valid=1 after edge N.
- Handshake:
  - A transfer happens when out_valid && out_ready.
  - If there is a transfer and no new accept, out_valid falls to 0 at the next edge.
  - If both happen in the same cycle, the new bundle replaces the old one and out_valid stays 1 (back-to-back throughput of 1 per cycle).
  - While out_valid && !out_ready, all outputs hold bit-stable.
- Flush:
  - Next edge forces out_valid=0.
  - An input presented in the same cycle is discarded even though in_ready may be 1.
  - Flush has priority over every other event.
  - Payload registers may retain old values.
- Immediate generation (ins = in_instr):
  - I = sext(ins[31:20])
  - S = sext({ins[31:25], ins[11:7]})
  - B = sext({ins[31], ins[7], ins[30:25], ins[11:8], 0})
  - U = sext({ins[31:12], 12'b0})
  - J = sext({ins[31], ins[19:12], ins[20], ins[30:21], 0})
- Format by opcode:
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111 → I; use_rs1=1.
  - STORE 0100011 → S; use_rs1=1, use_rs2=1.
  - BRANCH 1100011 → B; use_rs1=1, use_rs2=1.
  - LUI 0110111, AUIPC 0010111 → U; no source use.
  - JAL 1101111 → J; no source use.
  - OP 0110011 → none; use_rs1=1, use_rs2=1.
  - MISC-MEM 0001111, SYSTEM 1110011 → I, with use_rs1=1 only for SYSTEM funct3≠0.
  - XLEN=64 only: OP-IMM-32 0011011 → I; OP-32 0111011 → none, both sources used.
- Illegal detection (out_illegal=1, imm_sel=0, imm=0, use flags=0):
  - Any other opcode, or ins[1:0]≠11.
  - JALR with funct3≠0.
  - BRANCH with funct3 of 010 or 011.
  - XLEN=32 OP-IMM shift (funct3 001/101) with ins[25]=1.
- Illegal bundles still flow through the handshake normally; they are not dropped.
- Field outputs (rd, rs1, rs2, funct3, funct7, opcode) are always the raw bit slices, including on illegal instructions.

Test Plan:
- Reset and ALU/store immediates:
  - Reset mid-stream with out_valid=1 → out_valid=0 and all outputs 0 immediately, without waiting for a clock.
  - Then 0xFFF10093 (addi x1,x2,-1) → next cycle out_imm=0xFFFFFFFF, imm_sel=1, rd=1, rs1=2, use_rs1=1.
  - Then 0x00512423 (sw x5,8(x2)) → imm=0x8, imm_sel=2, rs1=2, rs2=5, both use flags 1.
- Branch/jump/upper immediates (XLEN=32):
  - 0xFE000EE3 → imm=0xFFFFFFFC, sel=3.
  - 0x001000EF → imm=0x00000800, sel=5, rd=1.
  - 0x123451B7 → imm=0x12345000, sel=4.
  - Repeat with XLEN=64 → 0xFFFFFFFFFFFFFFFC for the branch.
- Backpressure: 4 instructions streamed, out_ready low for 3 cycles on the 2nd → in_ready=0 in those cycles, outputs stable, no instruction lost or duplicated, order preserved, then 1 bundle per cycle once out_ready=1.
- Flush: flush with out_valid=1 and in_valid=1 in the same cycle → next cycle out_valid=0 and the input is not delivered. The following instruction is delivered normally.
- Illegal cases:
  - 0x00000000 → illegal=1, imm=0.
  - 0x02009093 at XLEN=32 → illegal=1; at XLEN=64 → legal, imm=0x20.
  - 0x0000303B at XLEN=32 → illegal.

Source files
------------

// File: rtl/id_pipe.sv
// Registered RISC-V instruction-decode stage: splits fields, builds sign-extended
// immediates, flags source use and illegal encodings, one-slot output with backpressure.
module id_pipe #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_sel,
    output logic            out_use_rs1,
    output logic            out_use_rs2,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_I    = 3'd1;
    localparam logic [2:0] SEL_S    = 3'd2;
    localparam logic [2:0] SEL_B    = 3'd3;
    localparam logic [2:0] SEL_U    = 3'd4;
    localparam logic [2:0] SEL_J    = 3'd5;

    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic              w_accept;
    logic [2:0]        w_sel;
    logic              w_use_rs1;
    logic              w_use_rs2;
    logic              w_illegal;
    logic [XLEN-1:0]   w_imm;
    logic signed [11:0] w_raw_i;
    logic signed [11:0] w_raw_s;
    logic signed [12:0] w_raw_b;
    logic signed [31:0] w_raw_u;
    logic signed [20:0] w_raw_j;

    logic              r_valid;
    logic [PC_W-1:0]   r_pc;
    logic [31:0]       r_instr;
    logic [XLEN-1:0]   r_imm;
    logic [2:0]        r_sel;
    logic              r_use_rs1;
    logic              r_use_rs2;
    logic              r_illegal;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready && !flush;

    assign w_raw_i = in_instr[31:20];
    assign w_raw_s = {in_instr[31:25], in_instr[11:7]};
    assign w_raw_b = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign w_raw_u = {in_instr[31:12], 12'b0};
    assign w_raw_j = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    // Every legal opcode ends in 2'b11, so compressed/malformed encodings fall to default.
    always_comb begin
        w_sel     = SEL_NONE;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_illegal = 1'b0;
        case (w_opcode)
            OPC_LOAD: begin
                w_sel     = SEL_I;
                w_use_rs1 = 1'b1;
            end
            OPC_OP_IMM: begin
                w_sel     = SEL_I;
                w_use_rs1 = 1'b1;
                if (XLEN == 32 && (w_funct3 == 3'b001 || w_funct3 == 3'b101) && in_instr[25])
                    w_illegal = 1'b1;
            end
            OPC_JALR: begin
                w_sel     = SEL_I;
                w_use_rs1 = 1'b1;
                if (w_funct3 != 3'b000)
                    w_illegal = 1'b1;
            end
            OPC_STORE: begin
                w_sel     = SEL_S;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                w_sel     = SEL_B;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                if (w_funct3 == 3'b010 || w_funct3 == 3'b011)
                    w_illegal = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: w_sel = SEL_U;
            OPC_JAL:            w_sel = SEL_J;
            OPC_OP: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OPC_MISC_MEM: w_sel = SEL_I;
            OPC_SYSTEM: begin
                w_sel     = SEL_I;
                w_use_rs1 = (w_funct3 != 3'b000);
            end
            OPC_OP_IMM32: begin
                w_sel     = SEL_I;
                w_use_rs1 = 1'b1;
                if (XLEN != 64)
                    w_illegal = 1'b1;
            end
            OPC_OP32: begin
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                if (XLEN != 64)
                    w_illegal = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_sel     = SEL_NONE;
            w_use_rs1 = 1'b0;
            w_use_rs2 = 1'b0;
        end
    end

    always_comb begin
        w_imm = '0;
        case (w_sel)
            SEL_I:   w_imm = XLEN'(w_raw_i);
            SEL_S:   w_imm = XLEN'(w_raw_s);
            SEL_B:   w_imm = XLEN'(w_raw_b);
            SEL_U:   w_imm = XLEN'(w_raw_u);
            SEL_J:   w_imm = XLEN'(w_raw_j);
            default: w_imm = '0;
        endcase
    end

    // Flush wins over both accept and transfer; payload is only written on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_instr   <= '0;
            r_imm     <= '0;
            r_sel     <= SEL_NONE;
            r_use_rs1 <= 1'b0;
            r_use_rs2 <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            if (flush)
                r_valid <= 1'b0;
            else if (w_accept)
                r_valid <= 1'b1;
            else if (out_ready)
                r_valid <= 1'b0;

            if (w_accept) begin
                r_pc      <= in_pc;
                r_instr   <= in_instr;
                r_imm     <= w_imm;
                r_sel     <= w_sel;
                r_use_rs1 <= w_use_rs1;
                r_use_rs2 <= w_use_rs2;
                r_illegal <= w_illegal;
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_pc      = r_pc;
    assign out_opcode  = r_instr[6:0];
    assign out_rd      = r_instr[11:7];
    assign out_funct3  = r_instr[14:12];
    assign out_rs1     = r_instr[19:15];
    assign out_rs2     = r_instr[24:20];
    assign out_funct7  = r_instr[31:25];
    assign out_imm     = r_imm;
    assign out_imm_sel = r_sel;
    assign out_use_rs1 = r_use_rs1;
    assign out_use_rs2 = r_use_rs2;
    assign out_illegal = r_illegal;

endmodule

// File: tb/tb_id_pipe.sv
// Directed bench for id_pipe: RV32 and RV64 instances share stimulus; vector table
// plus hand sequences for reset, backpressure and flush.
module tb_id_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_ready;

    logic        rdy32, val32, use1_32, use2_32, ill32;
    logic [31:0] pc32, imm32;
    logic [6:0]  opc32, f7_32;
    logic [4:0]  rd32, rs1_32, rs2_32;
    logic [2:0]  f3_32, sel32;

    logic        rdy64, val64, use1_64, use2_64, ill64;
    logic [31:0] pc64;
    logic [63:0] imm64;
    logic [6:0]  opc64, f7_64;
    logic [4:0]  rd64, rs1_64, rs2_64;
    logic [2:0]  f3_64, sel64;

    int checks = 0;
    int errors = 0;

    id_pipe #(.XLEN(32), .PC_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy32),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(val32),
        .out_ready(out_ready), .out_pc(pc32), .out_opcode(opc32), .out_rd(rd32),
        .out_rs1(rs1_32), .out_rs2(rs2_32), .out_funct3(f3_32), .out_funct7(f7_32),
        .out_imm(imm32), .out_imm_sel(sel32), .out_use_rs1(use1_32),
        .out_use_rs2(use2_32), .out_illegal(ill32)
    );

    id_pipe #(.XLEN(64), .PC_W(32)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy64),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(val64),
        .out_ready(out_ready), .out_pc(pc64), .out_opcode(opc64), .out_rd(rd64),
        .out_rs1(rs1_64), .out_rs2(rs2_64), .out_funct3(f3_64), .out_funct7(f7_64),
        .out_imm(imm64), .out_imm_sel(sel64), .out_use_rs1(use1_64),
        .out_use_rs2(use2_64), .out_illegal(ill64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  sel32;
        logic [31:0] imm32;
        logic        u1_32;
        logic        u2_32;
        logic        ill32;
        logic [2:0]  sel64;
        logic [63:0] imm64;
        logic        u1_64;
        logic        u2_64;
        logic        ill64;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc);
        @(negedge clk);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = 1'b1;
        flush     = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{32'hFFF10093, 5'd1, 5'd2, 5'd31, 3'd1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 3'd1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{32'h00512423, 5'd8, 5'd2, 5'd5,  3'd2, 32'h00000008, 1'b1, 1'b1, 1'b0, 3'd2, 64'h8, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{32'hFE000EE3, 5'd29, 5'd0, 5'd0, 3'd3, 32'hFFFFFFFC, 1'b1, 1'b1, 1'b0, 3'd3, 64'hFFFFFFFFFFFFFFFC, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{32'h001000EF, 5'd1, 5'd0, 5'd1,  3'd5, 32'h00000800, 1'b0, 1'b0, 1'b0, 3'd5, 64'h800, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{32'h123451B7, 5'd3, 5'd8, 5'd3,  3'd4, 32'h12345000, 1'b0, 1'b0, 1'b0, 3'd4, 64'h12345000, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'h800000B7, 5'd1, 5'd0, 5'd0,  3'd4, 32'h80000000, 1'b0, 1'b0, 1'b0, 3'd4, 64'hFFFFFFFF80000000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{32'h00000000, 5'd0, 5'd0, 5'd0,  3'd0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0, 64'h0, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{32'h02009093, 5'd1, 5'd1, 5'd0,  3'd0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd1, 64'h20, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{32'h0000303B, 5'd0, 5'd0, 5'd0,  3'd0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0, 64'h0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{32'h00009067, 5'd0, 5'd1, 5'd0,  3'd0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0, 64'h0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{32'h30529073, 5'd0, 5'd5, 5'd5,  3'd1, 32'h00000305, 1'b1, 1'b0, 1'b0, 3'd1, 64'h305, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{32'h00000073, 5'd0, 5'd0, 5'd0,  3'd1, 32'h0, 1'b0, 1'b0, 1'b0, 3'd1, 64'h0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{32'h00002063, 5'd0, 5'd0, 5'd0,  3'd0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0, 64'h0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{32'h0FF0000F, 5'd0, 5'd0, 5'd31, 3'd1, 32'h000000FF, 1'b0, 1'b0, 1'b0, 3'd1, 64'hFF, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{32'h003100B3, 5'd1, 5'd2, 5'd3,  3'd0, 32'h0, 1'b1, 1'b1, 1'b0, 3'd0, 64'h0, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{32'h00000012, 5'd0, 5'd0, 5'd0,  3'd0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0, 64'h0, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{32'h40115093, 5'd1, 5'd2, 5'd1,  3'd1, 32'h00000401, 1'b1, 1'b0, 1'b0, 3'd1, 64'h401, 1'b1, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        #2;
        checkOutput("reset_valid32", 64'(val32), 64'd0);
        checkOutput("reset_valid64", 64'(val64), 64'd0);
        checkOutput("reset_in_ready", 64'(rdy32), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Decode table, streamed back-to-back with the consumer always ready.
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i].instr, 32'h1000 + 32'(4 * i));
            checkOutput($sformatf("v%0d_valid32", i), 64'(val32), 64'd1);
            checkOutput($sformatf("v%0d_valid64", i), 64'(val64), 64'd1);
            checkOutput($sformatf("v%0d_pc", i), 64'(pc32), 64'(32'h1000 + 32'(4 * i)));
            checkOutput($sformatf("v%0d_rd", i), 64'(rd32), 64'(vecs[i].rd));
            checkOutput($sformatf("v%0d_rs1", i), 64'(rs1_32), 64'(vecs[i].rs1));
            checkOutput($sformatf("v%0d_rs2", i), 64'(rs2_32), 64'(vecs[i].rs2));
            checkOutput($sformatf("v%0d_sel32", i), 64'(sel32), 64'(vecs[i].sel32));
            checkOutput($sformatf("v%0d_imm32", i), 64'(imm32), 64'(vecs[i].imm32));
            checkOutput($sformatf("v%0d_use1_32", i), 64'(use1_32), 64'(vecs[i].u1_32));
            checkOutput($sformatf("v%0d_use2_32", i), 64'(use2_32), 64'(vecs[i].u2_32));
            checkOutput($sformatf("v%0d_ill32", i), 64'(ill32), 64'(vecs[i].ill32));
            checkOutput($sformatf("v%0d_rd64", i), 64'(rd64), 64'(vecs[i].rd));
            checkOutput($sformatf("v%0d_sel64", i), 64'(sel64), 64'(vecs[i].sel64));
            checkOutput($sformatf("v%0d_imm64", i), imm64, vecs[i].imm64);
            checkOutput($sformatf("v%0d_use1_64", i), 64'(use1_64), 64'(vecs[i].u1_64));
            checkOutput($sformatf("v%0d_use2_64", i), 64'(use2_64), 64'(vecs[i].u2_64));
            checkOutput($sformatf("v%0d_ill64", i), 64'(ill64), 64'(vecs[i].ill64));
        end

        // Last bundle is srai x1,x2,1: check the remaining raw slices.
        checkOutput("srai_opcode", 64'(opc32), 64'h13);
        checkOutput("srai_funct3", 64'(f3_32), 64'd5);
        checkOutput("srai_funct7", 64'(f7_32), 64'h20);

        // Hold the bundle, then pull reset between clock edges.
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("hold_valid", 64'(val32), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid32", 64'(val32), 64'd0);
        checkOutput("async_rst_valid64", 64'(val64), 64'd0);
        checkOutput("async_rst_pc", 64'(pc32), 64'd0);
        checkOutput("async_rst_imm32", 64'(imm32), 64'd0);
        checkOutput("async_rst_imm64", imm64, 64'd0);
        checkOutput("async_rst_rd", 64'(rd32), 64'd0);
        checkOutput("async_rst_opcode", 64'(opc32), 64'd0);
        checkOutput("async_rst_sel", 64'(sel32), 64'd0);
        checkOutput("async_rst_use1", 64'(use1_32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Backpressure: stall the second bundle for three cycles.
        begin
            int sent   = 0;
            int recv   = 0;
            int stalls = 0;
            int cyc    = 0;
            logic acc;
            while (recv < 4 && cyc < 30) begin
                @(negedge clk);
                in_valid = (sent < 4);
                in_instr = vecs[(sent < 4) ? sent : 0].instr;
                in_pc    = 32'h200 + 32'(4 * sent);
                if (val32 && recv == 1 && stalls < 3) begin
                    out_ready = 1'b0;
                    stalls++;
                end else begin
                    out_ready = 1'b1;
                end
                #1;
                if (!out_ready) begin
                    checkOutput($sformatf("bp_stall%0d_in_ready", stalls), 64'(rdy32), 64'd0);
                    checkOutput($sformatf("bp_stall%0d_pc", stalls), 64'(pc32), 64'h204);
                    checkOutput($sformatf("bp_stall%0d_imm", stalls), 64'(imm32), 64'(vecs[1].imm32));
                    checkOutput($sformatf("bp_stall%0d_rs2", stalls), 64'(rs2_32), 64'(vecs[1].rs2));
                end
                if (val32 && out_ready) begin
                    checkOutput($sformatf("bp_recv%0d_pc", recv), 64'(pc32), 64'(32'h200 + 32'(4 * recv)));
                    checkOutput($sformatf("bp_recv%0d_rd", recv), 64'(rd32), 64'(vecs[recv].rd));
                    recv++;
                end
                acc = in_valid && rdy32;
                cyc++;
                @(posedge clk);
                if (acc)
                    sent++;
            end
            in_valid = 1'b0;
            checkOutput("bp_received", 64'(recv), 64'd4);
            checkOutput("bp_stalls", 64'(stalls), 64'd3);
            checkOutput("bp_cycles", 64'(cyc), 64'd8);
        end

        // Flush wins over a same-cycle accept even while in_ready is high.
        @(negedge clk);
        in_valid  = 1'b1;
        in_instr  = vecs[1].instr;
        in_pc     = 32'h300;
        out_ready = 1'b0;
        flush     = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("fl_loaded_valid", 64'(val32), 64'd1);
        checkOutput("fl_loaded_pc", 64'(pc32), 64'h300);
        @(negedge clk);
        in_instr  = vecs[2].instr;
        in_pc     = 32'h304;
        out_ready = 1'b1;
        flush     = 1'b1;
        #1;
        checkOutput("fl_in_ready", 64'(rdy32), 64'd1);
        @(posedge clk);
        #1;
        checkOutput("fl_valid32", 64'(val32), 64'd0);
        checkOutput("fl_valid64", 64'(val64), 64'd0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("fl_not_delivered", 64'(val32), 64'd0);
        applyStimulus(vecs[3].instr, 32'h308);
        checkOutput("fl_next_valid", 64'(val32), 64'd1);
        checkOutput("fl_next_pc", 64'(pc32), 64'h308);
        checkOutput("fl_next_sel", 64'(sel32), 64'd5);
        checkOutput("fl_next_imm", 64'(imm32), 64'h800);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
